// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, the nop word, the fetch FSM encoding and the default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Next-PC selection, purely combinational: jump beats taken branch beats pc+4.
// Zero latency; no flow control of its own.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        br_cond,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc_plus4 + (sext16(instr[15:0]) << 2);

  // The opcode is decoded upstream; only the immediate/target fields matter here.
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && br_cond) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT FSM, bubble on stall, self-jump halt and saturating retire count.
// instr is valid in the same cycle as pc; redirects land next cycle; stall freezes all state and emits a nop.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_AW    = 6,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             br_cond,
  input  logic [31:0]      spoIM,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         fetch_en;
  logic         halt_hit;

  assign fetch_en = (state == ST_RUN) && !stall;
  assign instr    = fetch_en ? spoIM : INSTR_NOP;
  assign im_addr  = pc[IM_AW+1:2];

  npc_calc u_npc (
    .pc       (pc),
    .instr    (instr),
    .Branch   (Branch),
    .Jump     (Jump),
    .br_cond  (br_cond),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // A jump whose target is its own address can never make progress.
  assign halt_hit = Jump && (next_pc == pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_BOOT;
      pc      <= PC_RESET;
      retired <= '0;
      halted  <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          pc <= next_pc;
          if (retired != '1) begin
            retired <= retired + CNT_W'(1);
          end
          if (halt_hit) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS CPU, directly upstream of the instruction decoder.
- Holds the PC and drives the instruction-memory address.
- Presents the fetched word `instr` to the decoder, which feeds it into its `spoIM` input.
- Consumes the decoder's Branch/Jump outputs plus the ALU branch condition to select the next PC; adds bubble insertion on stall, a self-jump halt detector and a retired-instruction counter.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IM_AW, 6, instruction-memory word-address width (64 words).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and insert bubble this cycle.
- Branch  in  1  from decoder: current instruction is bgtz.
- Jump  in  1  from decoder: current instruction is j.
- br_cond  in  1  from ALU: branch condition true (rs > 0).
- spoIM  in  32  asynchronous-read instruction memory data.
- im_addr  out  IM_AW  word address to instruction memory, equal to pc[IM_AW+1:2].
- instr  out  32  instruction to decoder; 32'h0 (nop) when bubbled.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4.
- halted  out  1  high in HALT state.
- retired  out  CNT_W  count of instructions committed.

Behaviour:
- Reset is synchronous, active-high, and applies in any state, including mid-run. At the first clk edge with rst=1: pc=PC_RESET, state=BOOT, retired=0, halted=0.
- FSM has three states.
  - BOOT: lasts exactly one cycle after rst deasserts. instr=0, pc held, then goes to RUN. This gives the IM one settled address cycle.
  - RUN: normal fetch.
  - HALT: terminal until rst. instr=0, pc held, halted=1.
- instr = spoIM combinationally only when state==RUN && !stall; otherwise 32'h0. The decoder's default/nop path then suppresses every write.
- Next PC is computed combinationally; the priority order is jump, then branch, then sequential.
  - Jump=1: target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch=1 && br_cond=1: target = pc_plus4 + (sign_extend(instr[15:0]) << 2), using 32-bit wrap-around arithmetic.
  - Otherwise: pc_plus4.
  - Branch and Jump both 1 is illegal; jump wins.
- pc updates to next PC at the clk edge only when state==RUN && !stall.
- Halt detect: in RUN with !stall, if Jump=1 and jump target == pc, then at that edge state goes to HALT, pc stays, and retired still increments for the j.
- retired increments by 1 at each RUN edge with !stall. It saturates at all-ones and does not wrap.
- Stall wins over everything except rst. While stalled: pc, retired and state are unchanged, and instr=0.
- im_addr wrap: pc beyond 4*2^IM_AW aliases naturally via pc[IM_AW+1:2]. pc itself is full 32-bit and wraps 32'hFFFF_FFFC+4 to 0.
- Latency: instr is valid in the same cycle as pc (asynchronous IM); a redirect takes effect on the next cycle.
- No output is X after reset. All outputs are registered-state-derived or combinational from registered state plus inputs.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE 6'h00, OP_ADDI 6'h08, OP_LW 6'h23, OP_SW 6'h2B, OP_BGTZ 6'h07, OP_J 6'h02) and FUNCT_ADD 6'h20;
  - INSTR_NOP 32'h0;
  - fetch FSM state encoding (BOOT, RUN, HALT);
  - default PC_RESET.
- One sub-module, npc_calc: purely combinational. Inputs pc, instr, Branch, Jump, br_cond; outputs next_pc and pc_plus4. This keeps the FSM/counter shell under 200 lines.

Test Plan:
- Sequential fetch: IM holds addi words at 0..3, rst for 2 cycles then release. Expect instr=0 in BOOT, then pc = 0,4,8,12 on successive cycles, im_addr = 0,1,2,3, retired=4 after 4 RUN cycles.
- Branch taken: at pc=0x10 set instr=bgtz imm=16'hFFFE, Branch=1, br_cond=1. Expect next pc=0x0C. Repeat with br_cond=0 and expect next pc=0x14.
- Jump: at pc=0x08 set instr=j 26'h000_0010. Expect next pc=0x40. With Branch=1 and br_cond=1 also asserted, pc is still 0x40.
- Halt: at pc=0x20 set instr=j 26'h000_0008 (self). Expect halted=1 next cycle, pc stays 0x20, instr=0, retired +1 and then frozen across 10 cycles.
- Stall: assert stall for 3 cycles at pc=0x04 with a jump present. Expect pc=0x04, instr=0 and retired unchanged throughout; the jump executes on the first unstalled edge.
- Reset mid-run/wrap: with IM_AW=6, run to pc=0xFC; next pc=0x100 gives im_addr=0. Assert rst at pc=0x100 and expect pc=0, retired=0, state BOOT on the next edge.
